// File: rtl/mazecaster_pkg.sv
// Shared types and default timing for the player-movement command path.
package mazecaster_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_FWD,
    CMD_BACK,
    CMD_LEFT,
    CMD_RIGHT
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK
  } move_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 371250;
  localparam int DEF_REPEAT_FRAMES   = 4;
  localparam int DEF_ACK_TIMEOUT     = 16;

  // Opposing buttons cancel; survivors resolve FWD > BACK > LEFT > RIGHT.
  function automatic cmd_t resolve_cmd(input logic fwd, input logic back,
                                       input logic left, input logic right);
    cmd_t res;
    res = CMD_NONE;
    if (fwd && !back)        res = CMD_FWD;
    else if (back && !fwd)   res = CMD_BACK;
    else if (left && !right) res = CMD_LEFT;
    else if (right && !left) res = CMD_RIGHT;
    return res;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stable-count debounce for one raw push-button.
// MOVE_CMD_DEBOUNCE_EN enables the counter; otherwise the synchroniser output is used directly.
module button_debounce
  import mazecaster_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic pixel_clk_in,
  input  logic rst_n_in,
  input  logic btn_raw,
  output logic btn_db
);

  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

`ifdef MOVE_CMD_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             db_q;

  // Any cycle where the input agrees with the accepted state restarts the count.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (sync_q2 != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_q  <= sync_q2;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign btn_db = db_q;
`else
  assign btn_db = sync_q2;
`endif

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("button_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

endmodule

// File: rtl/move_cmd_gen.sv
// Conditions four movement buttons and issues one-cycle command strobes, then waits for the
// controller acknowledge. Debounce counters are present only with MOVE_CMD_DEBOUNCE_EN defined.
//   state    | meaning
//   IDLE     | waiting for a frame tick carrying a command to send
//   ISSUE    | single-cycle valid_out strobe with the latched command
//   WAIT_ACK | waiting for ctrl_done_in, bounded by ACK_TIMEOUT
module move_cmd_gen
  import mazecaster_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_FRAMES   = DEF_REPEAT_FRAMES,
  parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT
) (
  input  logic pixel_clk_in,
  input  logic rst_n_in,
  input  logic btn_fwd_in,
  input  logic btn_back_in,
  input  logic btn_left_in,
  input  logic btn_right_in,
  input  logic frame_tick_in,
  input  logic ctrl_done_in,
  output logic moveFwd,
  output logic moveBack,
  output logic rotLeft,
  output logic rotRight,
  output logic valid_out,
  output logic busy_out,
  output logic timeout_err_out
);

  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  logic [3:0] btn_raw;
  logic [3:0] btn_db;
  cmd_t       cmd_res;

  assign btn_raw = {btn_right_in, btn_left_in, btn_back_in, btn_fwd_in};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .pixel_clk_in(pixel_clk_in),
      .rst_n_in    (rst_n_in),
      .btn_raw     (btn_raw[i]),
      .btn_db      (btn_db[i])
    );
  end

  assign cmd_res = resolve_cmd(btn_db[0], btn_db[1], btn_db[2], btn_db[3]);

  move_state_t      state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  cmd_t             last_q, last_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             err_q, err_d;

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NONE;
      last_q  <= CMD_NONE;
      rep_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    last_d  = last_q;
    rep_d   = rep_q;
    to_d    = to_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (frame_tick_in) begin
          if (cmd_res == CMD_NONE) begin
            last_d = CMD_NONE;
            rep_d  = '0;
          end else if (cmd_res != last_q || rep_q == REP_LAST) begin
            cmd_d   = cmd_res;
            last_d  = cmd_res;
            rep_d   = '0;
            state_d = ISSUE;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        to_d    = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ctrl_done_in) begin
          state_d = IDLE;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid_out       = (state_q == ISSUE);
  assign moveFwd         = valid_out && (cmd_q == CMD_FWD);
  assign moveBack        = valid_out && (cmd_q == CMD_BACK);
  assign rotLeft         = valid_out && (cmd_q == CMD_LEFT);
  assign rotRight        = valid_out && (cmd_q == CMD_RIGHT);
  assign busy_out        = (state_q != IDLE);
  assign timeout_err_out = err_q;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Self-checking bench for move_cmd_gen: directed scenarios then randomized buttons, ticks and
// acknowledge delays, compared every cycle against a timeline model of the command interface.
module tb_move_cmd_gen;

  localparam int DBC = 4;
  localparam int RF  = 3;
  localparam int AT  = 8;
`ifdef MOVE_CMD_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btns;   // {right, left, back, fwd}
  logic       tick;
  logic       done;
  logic       moveFwd, moveBack, rotLeft, rotRight, valid_out, busy_out, timeout_err_out;

  always #5 clk = ~clk;

  move_cmd_gen #(
    .DEBOUNCE_CYCLES(DBC),
    .REPEAT_FRAMES  (RF),
    .ACK_TIMEOUT    (AT)
  ) dut (
    .pixel_clk_in   (clk),
    .rst_n_in       (rst_n),
    .btn_fwd_in     (btns[0]),
    .btn_back_in    (btns[1]),
    .btn_left_in    (btns[2]),
    .btn_right_in   (btns[3]),
    .frame_tick_in  (tick),
    .ctrl_done_in   (done),
    .moveFwd        (moveFwd),
    .moveBack       (moveBack),
    .rotLeft        (rotLeft),
    .rotRight       (rotRight),
    .valid_out      (valid_out),
    .busy_out       (busy_out),
    .timeout_err_out(timeout_err_out)
  );

  int checks   = 0;
  int failures = 0;

  // Timeline model: e_acc is the edge that accepted the last command (strobe visible right after
  // it), busy_until the edge that returns the interface to idle.
  int       cyc, e_acc, busy_until;
  bit       m_err;
  int       m_cmd, m_last, m_rep;
  bit [3:0] s1m, s2m, dbm;
  int       run[4];

  int ack_delay, ack_cnt, strobes, busy_cycles;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int resolve(input bit [3:0] d);
    bit f, b, l, r;
    f = d[0] && !d[1];
    b = d[1] && !d[0];
    l = d[2] && !d[3];
    r = d[3] && !d[2];
    return f ? 1 : b ? 2 : l ? 3 : r ? 4 : 0;
  endfunction

  task automatic model_reset();
    e_acc = -100; busy_until = -100; m_err = 1'b0;
    m_cmd = 0; m_last = 0; m_rep = 0;
    s1m = '0; s2m = '0; dbm = '0;
    for (int i = 0; i < 4; i++) run[i] = 0;
  endtask

  task automatic model_edge();
    bit [3:0] db_pre;
    bit       pre_busy;
    int       c, cmd;
    cyc++;
    c = cyc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    db_pre   = DEB_EN ? dbm : s2m;
    pre_busy = (c - 1 >= e_acc) && (c - 1 < busy_until);
    cmd      = resolve(db_pre);
    if (pre_busy) begin
      if (done && c >= e_acc + 2) busy_until = c;
      else if (c == e_acc + AT + 1) m_err = 1'b1;
    end else if (tick) begin
      if (cmd == 0) begin
        m_last = 0; m_rep = 0;
      end else if (cmd != m_last || m_rep == RF - 1) begin
        e_acc = c; busy_until = c + AT + 1;
        m_cmd = cmd; m_last = cmd; m_rep = 0;
      end else begin
        m_rep++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (dbm[i] != s2m[i]) begin
        run[i]++;
        if (run[i] == DBC) begin
          dbm[i] = s2m[i];
          run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    s2m = s1m;
    s1m = btns;
  endtask

  task automatic step();
    bit       exp_valid, exp_busy;
    bit [3:0] exp_bits;
    done = (ack_cnt == 0);
    if (ack_cnt >= 0) ack_cnt--;
    @(posedge clk);
    #1;
    model_edge();
    exp_valid = (cyc == e_acc);
    exp_busy  = (cyc >= e_acc) && (cyc < busy_until);
    exp_bits  = exp_valid ? 4'(1 << (m_cmd - 1)) : 4'b0000;
    chk("valid_out", {3'b000, valid_out}, {3'b000, exp_valid});
    chk("cmd_bits", {rotRight, rotLeft, moveBack, moveFwd}, exp_bits);
    chk("busy_out", {3'b000, busy_out}, {3'b000, exp_busy});
    chk("timeout_err", {3'b000, timeout_err_out}, {3'b000, m_err});
    if (valid_out) begin
      strobes++;
      if (ack_delay >= 0) ack_cnt = ack_delay;
    end
    if (busy_out) busy_cycles++;
    tick = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic tick_step();
    tick = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; btns = '0; tick = 1'b0; done = 1'b0;
    ack_delay = 1; ack_cnt = -1; strobes = 0; busy_cycles = 0; cyc = 0;
    model_reset();

    steps(3);
    chk("reset_outputs", {valid_out, busy_out, timeout_err_out,
                          moveFwd | moveBack | rotLeft | rotRight}, 4'b0000);
    rst_n = 1'b1;

    // 1: single forward press
    btns = 4'b0001;
    steps(10);
    strobes = 0;
    tick_step();
    chk("t1_fwd_strobe", {rotRight, rotLeft, moveBack, moveFwd}, 4'b0001);
    step();
    chk("t1_one_cycle", {3'b000, valid_out}, 4'b0000);
    steps(2);
    chk("t1_busy_fall", {3'b000, busy_out}, 4'b0000);
    chk("t1_strobe_count", 4'(strobes), 4'd1);

    // 2: held button repeats every RF ticks
    strobes = 0;
    repeat (7) begin
      tick_step();
      steps(4);
    end
    chk("t2_repeat_strobes", 4'(strobes), 4'd2);

    // 3: short glitch is rejected, sustained press is accepted
    btns = 4'b0000;
    steps(10);
    strobes = 0;
    btns[2] = 1'b1;
    steps(3);
    btns[2] = 1'b0;
    steps(6);
    tick_step();
    steps(3);
    chk("t3_glitch", 4'(strobes), 4'd0);
    btns[2] = 1'b1;
    steps(6);
    tick_step();
    chk("t3_left_strobe", {rotRight, rotLeft, moveBack, moveFwd}, 4'b0100);
    steps(3);

    // 4: conflict cancellation
    btns = 4'b1011;
    steps(10);
    tick_step();
    chk("t4_right_strobe", {rotRight, rotLeft, moveBack, moveFwd}, 4'b1000);
    steps(3);
    btns = 4'b1111;
    steps(10);
    strobes = 0;
    tick_step();
    steps(2);
    chk("t4_all_cancel", 4'(strobes), 4'd0);

    // 5: controller never acknowledges
    ack_delay = -1;
    btns = 4'b0001;
    steps(10);
    strobes = 0;
    busy_cycles = 0;
    tick_step();
    chk("t5_issue", {rotRight, rotLeft, moveBack, moveFwd}, 4'b0001);
    repeat (4) begin
      steps(2);
      tick_step();
    end
    chk("t5_busy_len", 4'(busy_cycles), 4'(AT + 1));
    chk("t5_strobes", 4'(strobes), 4'd1);
    chk("t5_err_set", {3'b000, timeout_err_out}, 4'b0001);
    steps(5);
    chk("t5_err_sticky", {3'b000, timeout_err_out}, 4'b0001);

    // 6: reset during WAIT_ACK, late acknowledge ignored
    btns = 4'b0000;
    steps(10);
    tick_step();
    btns = 4'b0010;
    steps(10);
    ack_delay = 3;
    tick_step();
    step();
    chk("t6_waiting", {3'b000, busy_out}, 4'b0001);
    rst_n = 1'b0;
    step();
    chk("t6_rst_outputs", {valid_out, busy_out, timeout_err_out,
                           moveFwd | moveBack | rotLeft | rotRight}, 4'b0000);
    rst_n = 1'b1;
    tick_step();
    chk("t6_no_issue_after_rst", {3'b000, valid_out}, 4'b0000);
    steps(4);
    chk("t6_late_ack", {2'b00, valid_out, busy_out}, 4'b0000);

    // randomized buttons, ticks, acknowledge delays and occasional resets
    repeat (60) begin
      btns = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0:       ack_delay = -1;
        1:       ack_delay = 0;
        2:       ack_delay = 1;
        3:       ack_delay = 2;
        default: ack_delay = 5;
      endcase
      repeat ($urandom_range(4, 16)) begin
        tick  = ($urandom_range(0, 3) == 0);
        rst_n = ($urandom_range(0, 39) != 0);
        step();
      end
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
